pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_if.sv | 19 +
 rtl/pipe_ctrl_sat_cnt16.sv | 17 +
 rtl/pipe_ctrl.sv | 49 ++++
 tb/tb_pipe_ctrl.sv | 137 +++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared Y86 encodings (icodes, register ids, status) and controller state type.
//    No ports; imported by the pipe_ctrl slice.
package pipe_ctrl_pkg;
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic       STAT_OK  = 1'b0;
   localparam logic       STAT_EXC = 1'b1;
   typedef enum logic {RUN, HALT} state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline-control bundle between the Y86 datapath and pipe_ctrl.
//    master: drives icodes/sources/condition/status, receives stall/bubble/set_cc/halted/counters.
//    slave : the controller side (mirror directions).
interface pipe_ctrl_if;
   logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic        e_Cnd, m_stat, W_stat;
   logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
   logic [15:0] lu_cnt, ret_cnt, mp_cnt;
   modport master (
      output D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, e_Cnd, m_stat, W_stat,
      input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted,
      input  lu_cnt, ret_cnt, mp_cnt
   );
   modport slave (
      input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, e_Cnd, m_stat, W_stat,
      output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted,
      output lu_cnt, ret_cnt, mp_cnt
   );
endinterface

// File: rtl/pipe_ctrl_sat_cnt16.sv
// sat_cnt16: 16-bit event counter that sticks at all-ones instead of wrapping.
//    clk, rst : clock / sync active-high reset
//    clr_i    : synchronous clear (wins over en_i)
//    en_i     : count one event this edge
//    q_o      : current count
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] q_o
);
   logic [15:0] q_q, q_d;
   always_comb q_d = (en_i && q_q != 16'hFFFF) ? q_q + 16'd1 : q_q;
   always_ff @(posedge clk) q_q <= (rst || clr_i) ? 16'd0 : q_d;
   assign q_o = q_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86 pipeline hazard controller with sticky halt and hazard event counters.
//    clk, rst : clock / sync active-high reset
//    bus      : pipe_ctrl_if.slave -- hazard inputs in, stall/bubble/set_cc/halted/counters out
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input logic         clk,
   input logic         rst,
   pipe_ctrl_if.slave  bus
);
   state_t state_q, state_d;
   logic   load_use, ret_hz, mispred, run;
   assign load_use = (bus.E_icode == IMRMOVQ || bus.E_icode == IPOPQ) && bus.E_dstM != RNONE &&
                     (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
   assign ret_hz   = bus.D_icode == IRET || bus.E_icode == IRET || bus.M_icode == IRET;
   assign mispred  = bus.E_icode == IJXX && !bus.e_Cnd;
   assign run      = state_q == RUN && !rst;
   always_comb state_d = (state_q == RUN && bus.W_stat == STAT_EXC) ? HALT : state_q;
   always_ff @(posedge clk) state_q <= rst ? RUN : state_d;
   // HALT freezes the whole pipe except D, which is held by stall rather than bubbled.
   always_comb begin
      bus.F_stall  = 1'b0;
      bus.D_stall  = 1'b0;
      bus.D_bubble = 1'b0;
      bus.E_bubble = 1'b0;
      bus.M_bubble = 1'b0;
      bus.W_stall  = 1'b0;
      bus.set_cc   = 1'b0;
      if (!rst && state_q == HALT) begin
         bus.F_stall  = 1'b1;
         bus.D_stall  = 1'b1;
         bus.E_bubble = 1'b1;
         bus.M_bubble = 1'b1;
         bus.W_stall  = 1'b1;
      end else if (!rst) begin
         bus.F_stall  = load_use || ret_hz;
         bus.D_stall  = load_use;
         bus.D_bubble = mispred || (ret_hz && !load_use);
         bus.E_bubble = mispred || load_use;
         bus.M_bubble = bus.m_stat == STAT_EXC || bus.W_stat == STAT_EXC;
         bus.W_stall  = bus.W_stat == STAT_EXC;
         bus.set_cc   = bus.E_icode == IOPQ && bus.m_stat == STAT_OK && bus.W_stat == STAT_OK;
      end
   end
   assign bus.halted = state_q == HALT;
   sat_cnt16 u_lu  (.clk(clk), .rst(rst), .clr_i(rst), .en_i(run && load_use), .q_o(bus.lu_cnt));
   sat_cnt16 u_ret (.clk(clk), .rst(rst), .clr_i(rst), .en_i(run && ret_hz),   .q_o(bus.ret_cnt));
   sat_cnt16 u_mp  (.clk(clk), .rst(rst), .clr_i(rst), .en_i(run && mispred),  .q_o(bus.mp_cnt));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   pipe_ctrl_if bus ();
   pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] outs();
      return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_stall, bus.set_cc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.D_icode = 4'h1; bus.E_icode = 4'h1; bus.M_icode = 4'h1;
      bus.d_srcA = 4'hF; bus.d_srcB = 4'hF; bus.E_dstM = 4'hF;
      bus.e_Cnd = 1'b1; bus.m_stat = 1'b0; bus.W_stat = 1'b0;
   endtask

   task automatic lu_on();
      bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      lu_on();
      bus.W_stat = 1'b1;
      #1 check("rst_outs", outs(), 7'b0);
      step();
      step();
      check("rst_halted", bus.halted, 0);
      check("rst_lu", bus.lu_cnt, 0);
      rst = 1'b0;
      idle();
      #1 check("idle_outs", outs(), 7'b0);
      lu_on();
      #1 check("lu_srcA_outs", outs(), 7'b1101000);
      check("lu_before", bus.lu_cnt, 0);
      step();
      check("lu_after", bus.lu_cnt, 1);
      idle();
      bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.d_srcB = 4'h4;
      #1 check("lu_popq_srcB", outs(), 7'b1101000);
      step();
      check("lu_two", bus.lu_cnt, 2);
      idle();
      bus.E_icode = 4'h5;
      #1 check("lu_rnone", outs(), 7'b0);
      step();
      check("lu_rnone_cnt", bus.lu_cnt, 2);
      idle();
      bus.D_icode = 4'h9;
      #1 check("ret_D", outs(), 7'b1010000);
      step();
      idle(); bus.E_icode = 4'h9;
      #1 check("ret_E", outs(), 7'b1010000);
      step();
      idle(); bus.M_icode = 4'h9;
      #1 check("ret_M", outs(), 7'b1010000);
      step();
      idle();
      check("ret_cnt3", bus.ret_cnt, 3);
      bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
      #1 check("mp_ret_outs", outs(), 7'b1011000);
      step();
      check("mp_cnt1", bus.mp_cnt, 1);
      check("mp_ret_cnt", bus.ret_cnt, 4);
      bus.e_Cnd = 1'b1; bus.D_icode = 4'h1;
      #1 check("jxx_taken", outs(), 7'b0);
      step();
      check("jxx_taken_cnt", bus.mp_cnt, 1);
      idle();
      lu_on(); bus.D_icode = 4'h9;
      #1 check("lu_over_ret", outs(), 7'b1101000);
      step();
      check("lu_ret_lu", bus.lu_cnt, 3);
      check("lu_ret_ret", bus.ret_cnt, 5);
      idle();
      bus.E_icode = 4'h6;
      #1 check("opq_setcc", outs(), 7'b0000001);
      bus.m_stat = 1'b1;
      #1 check("opq_mstat", outs(), 7'b0000100);
      bus.W_stat = 1'b1;
      #1 check("opq_wstat", outs(), 7'b0000110);
      check("pre_halt", bus.halted, 0);
      step();
      check("halted", bus.halted, 1);
      idle();
      #1 check("halt_outs", outs(), 7'b1101110);
      lu_on(); bus.D_icode = 4'h9;
      step();
      step();
      check("halt_sticky", bus.halted, 1);
      check("halt_lu_frozen", bus.lu_cnt, 3);
      check("halt_ret_frozen", bus.ret_cnt, 5);
      check("halt_outs_lu", outs(), 7'b1101110);
      bus.D_icode = 4'h1;
      rst = 1'b1;
      #1 check("rst_in_halt_outs", outs(), 7'b0);
      step();
      rst = 1'b0;
      #1 check("rst_exit_halted", bus.halted, 0);
      check("rst_exit_lu", bus.lu_cnt, 0);
      check("rst_exit_ret", bus.ret_cnt, 0);
      check("rst_exit_mp", bus.mp_cnt, 0);
      check("rst_exit_outs", outs(), 7'b1101000);
      rst = 1'b1; bus.W_stat = 1'b1;
      step();
      rst = 1'b0; bus.W_stat = 1'b0;
      #1 check("rst_over_halt", bus.halted, 0);
      check("rst_over_halt_lu", bus.lu_cnt, 0);
      repeat (65534) @(posedge clk);
      #1 check("lu_fffe", bus.lu_cnt, 16'hFFFE);
      step();
      check("lu_ffff", bus.lu_cnt, 16'hFFFF);
      step();
      check("lu_sat", bus.lu_cnt, 16'hFFFF);
      check("lu_sat_ret", bus.ret_cnt, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
